// File: rtl/sram_fifo_pkg.sv
// sram_fifo shared definitions: staging depth and pointer wrap helper.
// Optional bypass path in sram_fifo is enabled with SRAM_FIFO_BYPASS_EN.
package sram_fifo_pkg;

    localparam int STAGE_N = 3;

    // Advance a pointer, wrapping from words_n-1 back to 0.
    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned words_n
    );
        return (ptr == words_n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sram_fifo_stage.sv
// sram_fifo_stage: 3-entry flop FIFO holding words read back from SRAM.
// Head is always entry 0, so the consumer sees a registered output.
module sram_fifo_stage
    import sram_fifo_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [WORD_W-1:0] head,
    output logic              vld
);

    logic [WORD_W-1:0] mem [STAGE_N];
    logic [1:0]        cnt_q;
    logic              do_pop;
    logic [1:0]        wr_idx;

    // Pop shifts everything down, so a same-cycle push lands one slot lower.
    always_comb begin
        do_pop = pop & (cnt_q != 2'd0);
        wr_idx = do_pop ? cnt_q - 2'd1 : cnt_q;
    end

    // Shift-register storage with occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < STAGE_N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                for (int i = 0; i < STAGE_N - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_idx] <= push_data;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

    assign cnt  = cnt_q;
    assign head = mem[0];
    assign vld  = (cnt_q != 2'd0);

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        push |-> ((cnt_q != 2'(STAGE_N)) || do_pop)
    );

endmodule

// File: rtl/sram_fifo.sv
// sram_fifo: valid/ready FIFO using a single-port SRAM as bulk storage.
// Define SRAM_FIFO_BYPASS_EN to let words skip the SRAM when it is empty.
module sram_fifo
    import sram_fifo_pkg::*;
#(
    parameter  int WORD_W  = 32,
    parameter  int WORDS_N = 256,
    localparam int ADDR_W  = $clog2(WORDS_N),
    localparam int OCC_W   = $clog2(WORDS_N + 4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_vld,
    input  logic [WORD_W-1:0] push_data,
    output logic              push_rdy,
    output logic              pop_vld,
    output logic [WORD_W-1:0] pop_data,
    input  logic              pop_rdy,
    output logic              sram_ce,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [WORD_W-1:0] sram_din,
    output logic              sram_rnw,
    input  logic [WORD_W-1:0] sram_dout,
    output logic [OCC_W-1:0]  occupancy
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [OCC_W-1:0]  sram_cnt;
    logic              rd_inflight;
    logic [1:0]        stage_cnt;
    logic              rd_sel;
    logic              wr_fire;
    logic              byp_ok;
    logic              byp_fire;
    logic              stage_push;
    logic              stage_pop;
    logic [WORD_W-1:0] stage_din;

    // Port arbitration: refill reads win over pushes into the SRAM.
    always_comb begin
        rd_sel = ~rst
               & (sram_cnt != '0)
               & (({1'b0, stage_cnt} + {2'b0, rd_inflight}) < 3'(STAGE_N));
        stage_pop = pop_vld & pop_rdy;
`ifdef SRAM_FIFO_BYPASS_EN
        byp_ok = ~rst
               & (sram_cnt == '0)
               & ~rd_inflight
               & ((stage_cnt != 2'(STAGE_N)) | stage_pop);
`else
        byp_ok = 1'b0;
`endif
        push_rdy   = ~rst
                   & (((sram_cnt != OCC_W'(WORDS_N)) & ~rd_sel) | byp_ok);
        byp_fire   = push_vld & byp_ok;
        wr_fire    = push_vld & push_rdy & ~byp_ok;
        stage_push = rd_inflight | byp_fire;
        stage_din  = rd_inflight ? sram_dout : push_data;
        sram_ce    = rd_sel | wr_fire;
        sram_rnw   = rd_sel;
        sram_addr  = rst ? '0 : (rd_sel ? rd_ptr : wr_ptr);
        sram_din   = rst ? '0 : push_data;
    end

    // Pointers, SRAM word count and the one-cycle read return flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= rd_sel;
            if (wr_fire) begin
                wr_ptr <= ADDR_W'(ptr_inc(32'(wr_ptr), WORDS_N));
            end
            if (rd_sel) begin
                rd_ptr <= ADDR_W'(ptr_inc(32'(rd_ptr), WORDS_N));
            end
            if (wr_fire) begin
                sram_cnt <= sram_cnt + 1'b1;
            end else if (rd_sel) begin
                sram_cnt <= sram_cnt - 1'b1;
            end
        end
    end

    sram_fifo_stage #(
        .WORD_W(WORD_W)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .push      (stage_push),
        .push_data (stage_din),
        .pop       (stage_pop),
        .cnt       (stage_cnt),
        .head      (pop_data),
        .vld       (pop_vld)
    );

    assign occupancy = sram_cnt
                     + OCC_W'(rd_inflight)
                     + OCC_W'(stage_cnt);

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (rst)
        sram_cnt <= OCC_W'(WORDS_N)
    );

    a_capture_src: assert property (
        @(posedge clk) disable iff (rst)
        (stage_push & ~byp_fire) |-> rd_inflight
    );

    a_no_rw_clash: assert property (
        @(posedge clk) disable iff (rst)
        !(rd_sel && wr_fire)
    );

endmodule

// File: tb/tb_sram_fifo.sv
// Self-checking bench for sram_fifo with a behavioural SRAM and queue model.
// Build with SRAM_FIFO_BYPASS_EN to exercise the bypass latency expectations.
module tb_sram_fifo;

    localparam int W  = 32;
    localparam int N  = 12;
    localparam int AW = $clog2(N);
    localparam int OW = $clog2(N + 4);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_vld;
    logic [W-1:0]  push_data;
    logic          push_rdy;
    logic          pop_vld;
    logic [W-1:0]  pop_data;
    logic          pop_rdy;
    logic          sram_ce;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_din;
    logic          sram_rnw;
    logic [W-1:0]  sram_dout;
    logic [OW-1:0] occupancy;

    int vectors = 0;
    int errs    = 0;
    bit rand_pop = 1'b0;

    sram_fifo #(
        .WORD_W  (W),
        .WORDS_N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_vld  (push_vld),
        .push_data (push_data),
        .push_rdy  (push_rdy),
        .pop_vld   (pop_vld),
        .pop_data  (pop_data),
        .pop_rdy   (pop_rdy),
        .sram_ce   (sram_ce),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_rnw  (sram_rnw),
        .sram_dout (sram_dout),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: dout valid the cycle after a read.
    logic [W-1:0] smem [N];
    logic [W-1:0] sdout = '0;
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_rnw) sdout <= smem[sram_addr];
            else smem[sram_addr] <= sram_din;
        end
    end
    assign sram_dout = sdout;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: FIFO order, word count, and SRAM address sequence.
    logic [W-1:0] q[$];
    int cnt  = 0;
    int wr_n = 0;
    int rd_n = 0;

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        if (rst) begin
            chk("rst_push_rdy", 64'(push_rdy), 64'd0);
            chk("rst_sram_ce", 64'(sram_ce), 64'd0);
            q.delete();
            cnt  = 0;
            wr_n = 0;
            rd_n = 0;
        end else begin
            chk("occupancy", 64'(occupancy), 64'(cnt));
            chk("pop_vld_when_empty", 64'(pop_vld && cnt == 0), 64'd0);
            if (cnt == N + 3) chk("full_push_rdy", 64'(push_rdy), 64'd0);
            if (sram_ce && !sram_rnw) begin
                chk("sram_wr_addr", 64'(sram_addr), 64'(wr_n % N));
                chk("sram_din", 64'(sram_din), 64'(push_data));
                chk("sram_wr_fire", 64'(push_vld && push_rdy), 64'd1);
                wr_n++;
            end
            if (sram_ce && sram_rnw) begin
                chk("sram_rd_addr", 64'(sram_addr), 64'(rd_n % N));
                chk("sram_rd_after_wr", 64'(rd_n < wr_n), 64'd1);
                rd_n++;
            end
            if (pop_vld && pop_rdy) begin
                if (q.size() == 0) begin
                    chk("pop_underflow", 64'(q.size()), 64'd1);
                end else begin
                    exp_w = q.pop_front();
                    chk("pop_data", 64'(pop_data), 64'(exp_w));
                end
                cnt--;
            end
            if (push_vld && push_rdy) begin
                q.push_back(push_data);
                cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_pop) pop_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic push_word(input logic [W-1:0] d);
        bit ok = 1'b0;
        push_vld  = 1'b1;
        push_data = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = push_rdy;
            tick();
        end
        push_vld = 1'b0;
        chk("push_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        rand_pop = 1'b0;
        pop_rdy  = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (occupancy == '0) && !pop_vld;
        end
        chk("drain_done", 64'(done), 64'd1);
        chk("model_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [7:0] rdy_bits;
        logic [W-1:0] nxt;
        bit got;
        rst       = 1'b1;
        push_vld  = 1'b0;
        push_data = '0;
        pop_rdy   = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_pop_vld", 64'(pop_vld), 64'd0);
        chk("idle_push_rdy", 64'(push_rdy), 64'd1);
        chk("idle_sram_ce", 64'(sram_ce), 64'd0);

        // Single word latency
        tick();
        push_vld  = 1'b1;
        push_data = 32'hA5A5_0001;
        pop_rdy   = 1'b1;
        @(negedge clk);
`ifdef SRAM_FIFO_BYPASS_EN
        chk("single_n0_ce", 64'(sram_ce), 64'd0);
        tick();
        push_vld = 1'b0;
        @(negedge clk);
        chk("single_n1_vld", 64'(pop_vld), 64'd1);
        chk("single_n1_data", 64'(pop_data), 64'hA5A5_0001);
        chk("single_n1_ce", 64'(sram_ce), 64'd0);
        @(negedge clk);
        chk("single_n2_occ", 64'(occupancy), 64'd0);
`else
        chk("single_n0_ce", 64'(sram_ce), 64'd1);
        chk("single_n0_rnw", 64'(sram_rnw), 64'd0);
        tick();
        push_vld = 1'b0;
        @(negedge clk);
        chk("single_n1_rd", 64'({sram_ce, sram_rnw}), 64'd3);
        @(negedge clk);
        chk("single_n2_vld", 64'(pop_vld), 64'd0);
        chk("single_n2_occ", 64'(occupancy), 64'd1);
        @(negedge clk);
        chk("single_n3_vld", 64'(pop_vld), 64'd1);
        chk("single_n3_data", 64'(pop_data), 64'hA5A5_0001);
        @(negedge clk);
        chk("single_n4_occ", 64'(occupancy), 64'd0);
`endif
        tick();
        pop_rdy = 1'b0;
        tick();

        // Contention pattern then fill to full, pop_rdy held low
        nxt       = '0;
        push_vld  = 1'b1;
        push_data = nxt;
        rdy_bits  = '0;
        for (int c = 0; c < 200 && nxt < 15; c++) begin
            @(negedge clk);
            got = push_rdy;
            if (c < 8) rdy_bits[c] = push_rdy;
            tick();
            if (got) nxt++;
            push_data = nxt;
        end
`ifdef SRAM_FIFO_BYPASS_EN
        chk("contention_rdy", 64'(rdy_bits), 64'hFF);
`else
        chk("contention_rdy", 64'(rdy_bits), 64'hD5);
`endif
        chk("fill_count", 64'(nxt), 64'd15);
        repeat (3) begin
            @(negedge clk);
            chk("full_rdy_low", 64'(push_rdy), 64'd0);
        end
        tick();
        push_vld = 1'b0;
        @(negedge clk);
        chk("full_occ", 64'(occupancy), 64'd15);
        chk("full_head_vld", 64'(pop_vld), 64'd1);
        chk("full_head_data", 64'(pop_data), 64'd0);
        tick();
        drain();
        tick();

        // Streaming with incrementing data
        nxt       = 32'h5000_0000;
        pop_rdy   = 1'b1;
        push_vld  = 1'b1;
        push_data = nxt;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            got = push_rdy;
            tick();
            if (got) nxt++;
            push_data = nxt;
        end
        push_vld = 1'b0;
        chk("stream_progress", 64'(nxt > 32'h5000_0040), 64'd1);
        drain();
        tick();

        // Wrap-around with random consumer stalls
        rand_pop = 1'b1;
        for (int i = 0; i < 40; i++) push_word(32'hC000_0000 + i);
        drain();
        tick();

        // Reset while a read is in flight
        pop_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + i);
        repeat (6) tick();
        @(negedge clk);
        chk("mid_occ8", 64'(occupancy), 64'd8);
        tick();
        pop_rdy = 1'b1;
        tick();
        pop_rdy = 1'b0;
        @(negedge clk);
        chk("mid_read_issue", 64'({sram_ce, sram_rnw}), 64'd3);
        chk("mid_occ7", 64'(occupancy), 64'd7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_occ", 64'(occupancy), 64'd0);
        chk("post_rst_vld", 64'(pop_vld), 64'd0);
        chk("post_rst_ce", 64'(sram_ce), 64'd0);
        tick();
        pop_rdy = 1'b1;
        push_word(32'h0000_1234);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = pop_vld;
        end
        chk("post_rst_pop_seen", 64'(got), 64'd1);
        chk("post_rst_pop_data", 64'(pop_data), 64'h1234);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/sram_fifo.md
Name: sram_fifo

Overview:
- Valid/ready FIFO controller that sits directly upstream of generic_sram and drives its ce/addr/din/rnw port.
- Uses the single-ported SRAM as bulk storage. It consumes generic_sram dout, which is valid only the cycle after a read.
- Read data is captured into a small flop staging buffer, giving the consumer a registered, stallable output.
- Arbitrates the single SRAM port between writes (push) and reads (refill of staging).

Parameters:
- WORD_W, 32, data width in bits; matches the generic_sram WORD_W.
- WORDS_N, 256, SRAM depth in words; must be >= 2; need not be a power of two.
- ADDR_W (localparam), $clog2(WORDS_N), SRAM address width.
- OCC_W (localparam), $clog2(WORDS_N + 4), occupancy width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- push_vld  in  1  producer has a word.
- push_data  in  WORD_W  producer word.
- push_rdy  out  1  word accepted when push_vld & push_rdy.
- pop_vld  out  1  head word is valid.
- pop_data  out  WORD_W  head word.
- pop_rdy  in  1  consumer takes the word when pop_vld & pop_rdy.
- sram_ce  out  1  to generic_sram ce.
- sram_addr  out  ADDR_W  to generic_sram addr.
- sram_din  out  WORD_W  to generic_sram din.
- sram_rnw  out  1  to generic_sram rnw; 1 = read.
- sram_dout  in  WORD_W  from generic_sram dout.
- occupancy  out  OCC_W  words held: SRAM + in-flight read + staging.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - push_rdy=0, pop_vld=0, sram_ce=0, occupancy=0.
  - wr_ptr=0, rd_ptr=0, sram_cnt=0, rd_inflight=0.
  - Staging buffer empty.
  - pop_data and sram_addr/din are don't-care, but held at 0 in reset.
- State:
  - wr_ptr and rd_ptr (ADDR_W each).
  - sram_cnt (0..WORDS_N).
  - rd_inflight (1 bit).
  - Staging FIFO of 3 entries, stage_cnt (0..3).
- Read select: rd_sel = (sram_cnt != 0) & (stage_cnt + rd_inflight < 3). Read has priority over write.
- Write select:
  - push_rdy = (sram_cnt != WORDS_N) & ~rd_sel & ~rst. This is combinational from internal state only, never from push_vld.
  - wr_fire = push_vld & push_rdy.
- SRAM drive:
  - sram_ce = rd_sel | wr_fire.
  - sram_rnw = rd_sel.
  - sram_addr = rd_sel ? rd_ptr : wr_ptr.
  - sram_din = push_data.
- Read completion: rd_inflight <= rd_sel. When rd_inflight=1, sram_dout is written into staging at the clock edge.
- Pointers increment on their operation and wrap from WORDS_N-1 to 0.
- sram_cnt update: +1 on wr_fire, -1 on rd_sel. Both cannot occur in the same cycle.
- Staging output: pop_vld = (stage_cnt != 0) and pop_data = head entry, both from flops.
- Pop and capture in the same cycle: stage_cnt is unchanged and FIFO ordering is preserved.
- Latency:
  - Push at cycle N gives pop_vld at N+3 when the SRAM and staging are empty and the port is uncontended.
  - Sustained pop throughput is 1 word/cycle while the SRAM is non-empty.
- Full (sram_cnt == WORDS_N): push_rdy=0. A read frees space; push_rdy rises the following cycle.
- Empty: pop_vld=0. occupancy=0 only when sram_cnt, rd_inflight and stage_cnt are all 0.
- Fairness: writes are starved only while the SRAM is draining into staging, which is bounded by WORDS_N cycles.
- Reset mid-operation: all contents are discarded. A read in flight at reset is dropped and sram_dout is ignored in the cycle after reset.
- occupancy = sram_cnt + rd_inflight + stage_cnt, registered-equivalent (derived from flops only).
- Assertions:
  - No staging overflow.
  - sram_cnt never exceeds WORDS_N.
  - No capture when rd_inflight=0.

Optional Feature:
- Macro: SRAM_FIFO_BYPASS_EN.
- Defined: when sram_cnt==0, rd_inflight==0 and stage_cnt<3 (with a same-cycle pop counted as freeing a slot), push_rdy=1 and an accepted word is written directly into staging without using the SRAM.
  - Push at N gives pop_vld at N+1.
  - sram_ce stays 0 for a bypassed word.
  - Ordering is preserved because bypass is only legal when the SRAM is empty and nothing is in flight.
- Undefined: every word passes through the SRAM; latency is 3.

Decomposition:
- Package sram_fifo_pkg holds:
  - localparam STAGE_N = 3.
  - Helper function ptr_inc(ptr, WORDS_N) for the wrap.
- Sub-module sram_fifo_stage: a 3-entry flop FIFO (push/pop/cnt, same-cycle push+pop) used for staging.
- Top-level sram_fifo holds the pointers, counters, port arbitration and bypass logic.

Test Plan:
- Single word: push 0xA5A5_0001 at cycle 5, pop_rdy=1 → sram write at 5, read at 6, pop_vld with 0xA5A5_0001 at cycle 8; occupancy returns to 0 at 9. With BYPASS_EN, pop_vld is at 6 and sram_ce is never asserted.
- Fill to full (WORDS_N=16, pop_rdy=0): push 0..18 → staging holds 0..2 and the SRAM fills with 3..18. push_rdy=0 with occupancy=19; data pops in order 0..18.
- Streaming: push_vld=1 and pop_rdy=1 continuously with an incrementing pattern for 200 cycles → no reorder, no loss, and sram_cnt stays ≤ WORDS_N.
- Wrap-around (WORDS_N=12, non-power-of-two): 40 pushes interleaved with random pop_rdy → pointers wrap 11→0 and the output sequence exactly matches the input sequence.
- Contention: stage_cnt=0, sram_cnt=5, push_vld=1 → push_rdy=0 until stage_cnt+rd_inflight=3; the first write is issued the cycle read selection drops.
- Reset mid-read: assert rst the cycle after a read issue with occupancy=7 → the next cycle has occupancy=0, pop_vld=0 and sram_ce=0. A subsequent push of 0x1234 pops as 0x1234 with no stale data.
